player_motion_integrator: RTL and testbench
===========================================

Name: player_motion_integrator

Overview:
- Upstream neighbour of the VGA display stage: converts raw accelerometer samples into the player-box centre coordinates consumed as accel_x/accel_y.
- Once per frame, it integrates acceleration into velocity and velocity into position, saturating both.
- Position is clamped so the player box always stays on screen.
- Outputs change only during a single commit cycle, so the display never sees a torn update.

Parameters:
- SCREEN_W, 640: visible width in pixels.
- SCREEN_H, 480: visible height in pixels.
- HALF_SIZE, 20: player box half-width; sets the clamp margin.
- ACCEL_W, 12: width of the signed raw accelerometer samples.
- ACCEL_SHIFT, 4: arithmetic right shift applied to the dead-zoned sample.
- DEADZONE, 8: raw magnitude below which the sample is treated as 0.
- VMAX, 15: velocity saturation magnitude, in pixels per frame.

Ports:
- clk_25mHz  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- screenEnd  in  1  from the timing generator; high between frames.
- enable  in  1  game running; when low, no integration occurs.
- recenter  in  1  level request to return to the screen centre.
- accel_valid  in  1  raw sample is present.
- accel_ready  out  1  block can accept a sample.
- accel_raw_x  in  ACCEL_W  signed raw X sample.
- accel_raw_y  in  ACCEL_W  signed raw Y sample.
- pos_x  out  32  player centre X, zero-extended.
- pos_y  out  32  player centre Y, zero-extended.
- vel_x  out  8  signed X velocity, for debug and scoring.
- vel_y  out  8  signed Y velocity.
- wall_hit  out  1  one-cycle pulse when any axis clamps.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Clock and reset: single clock domain. reset is asynchronous and active-high.
- Reset values:
  - pos_x = SCREEN_W/2 (320); pos_y = SCREEN_H/2 (240).
  - vel_x = vel_y = 0.
  - wall_hit = 0, busy = 0, accel_ready = 1.
  - Sample registers = 0; FSM in IDLE.
- Sample capture:
  - accel_ready = 1 only in IDLE.
  - On accel_valid && accel_ready, sample_x/sample_y are overwritten with the new values; the latest sample wins.
  - While not ready, valid is ignored. No sample is lost for the integration step, because that step uses the value captured before FILTER.
- Frame tick: the rising edge of screenEnd, detected with one registered copy. This produces a single-cycle tick regardless of the screenEnd pulse length.
- FSM states: IDLE, FILTER, VEL, POS, COMMIT.
  - IDLE -> FILTER: on tick && enable. A tick while enable = 0 is ignored and the state stays IDLE.
  - FILTER: per axis, a = (|s| < DEADZONE) ? 0 : s >>> ACCEL_SHIFT (arithmetic shift).
  - VEL: v' = saturate(v + a, -VMAX, +VMAX), computed at ACCEL_W+1 bits before saturation.
  - POS: p' = p + v', computed signed at 12 bits. Clamp to [HALF_SIZE, SCREEN_W-1-HALF_SIZE] for X and [HALF_SIZE, SCREEN_H-1-HALF_SIZE] for Y. If an axis clamps, that axis's v' is forced to 0 and a clamp flag is set.
  - COMMIT: pos, vel and wall_hit (OR of the clamp flags) register together; then return to IDLE.
- Timing and latency:
  - Outputs update exactly 4 cycles after the tick.
  - wall_hit is high for that one cycle only.
  - The display stage samples on screenEnd falling, so the effective display latency is one frame.
- recenter:
  - In IDLE, it loads the centre position and zero velocity on the next edge.
  - If asserted during FILTER..POS, it takes effect at COMMIT, overriding the computed values; wall_hit = 0 in that case.
- enable falling mid-sequence: the sequence completes normally; no abort.
- Reset mid-sequence: immediate return to the reset values.

Optional Feature:
- Macro: FRICTION_EN.
- When defined: in VEL, if the filtered a == 0 and v != 0, v moves 1 toward 0 per frame.
- When undefined: v is retained unchanged when a == 0.

Decomposition:
- square_game_pkg holds:
  - SCREEN_W/SCREEN_H defaults and the centre constants;
  - the FSM state enum;
  - the velocity and position widths.
- Sub-module axis_integrator performs the dead-zone, shift, saturation and clamp for one axis.
- It is parameterised by the axis limit and instantiated twice (X, Y); the top level holds the FSM, handshake, tick detection and recenter logic.

Test Plan:
- Reset, then hold sample (0,0) for 3 frames -> pos stays (320,240), vel (0,0), wall_hit never asserts.
- Sample x = +160, y = 0, enable = 1 -> a = 10 each frame:
  - Frame 1: vel_x = 10, pos_x = 330. Frame 2: vel_x = 15 (saturated), pos_x = 345.
  - Outputs change exactly 4 cycles after the screenEnd rise.
- Sample x = +5 (below DEADZONE) -> a = 0. Velocity is held without FRICTION_EN; it decays by 1 per frame with FRICTION_EN.
- Sustained x = +2000 -> pos_x reaches 619 (the clamp); on that commit vel_x = 0 and wall_hit pulses for exactly 1 cycle.
- recenter asserted during VEL with pos_x = 500 -> at COMMIT, pos = (320,240), vel = 0, wall_hit = 0.
- accel_valid held high across ticks -> accel_ready drops for cycles tick+1..tick+4; a sample presented then is taken in IDLE; an async reset in POS returns pos to (320,240) immediately.

Source files
------------

// File: rtl/square_game_pkg.sv
// -----------------------------------------------------------------------------
// square_game_pkg
// Shared constants and types for the player motion path of the square game.
//   - Default screen geometry (the centre is derived with centre_of()).
//   - Velocity / position datapath widths.
//   - Motion sequencer state encoding.
// -----------------------------------------------------------------------------
package square_game_pkg;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  // Velocity is signed pixels/frame; position is computed signed so that a
  // step past the left/top edge is seen as negative before clamping.
  localparam int VEL_W = 8;
  localparam int POS_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILTER = 3'd1,
    ST_VEL    = 3'd2,
    ST_POS    = 3'd3,
    ST_COMMIT = 3'd4
  } motion_state_t;

  function automatic logic [POS_W-1:0] centre_of(input int len);
    return POS_W'(len / 2);
  endfunction

endpackage

// File: rtl/axis_integrator.sv
// -----------------------------------------------------------------------------
// axis_integrator
// One axis of the player motion datapath. Three strobed stages:
//   filter_en : dead-zone + arithmetic shift of the raw sample   -> accel_p0
//   vel_en    : v' = sat(v + a) (optional friction, FRICTION_EN) -> vel_p1
//   pos_en    : p' = clamp(p + v'), zeroing v' on a clamp        -> pos_p2
// Ports:
//   clk                       clock
//   filter_en/vel_en/pos_en   stage strobes from the sequencer
//   sample                    signed raw accelerometer sample
//   vel_cur / pos_cur         currently committed velocity / position
//   vel_nxt / pos_nxt / clamp results held until the commit
// Build option: FRICTION_EN -- with no acceleration, velocity decays by 1.
// -----------------------------------------------------------------------------
module axis_integrator
  import square_game_pkg::*;
#(
  parameter int ACCEL_W     = 12,
  parameter int ACCEL_SHIFT = 4,
  parameter int DEADZONE    = 8,
  parameter int VMAX        = 15,
  parameter int AXIS_LEN    = 640,
  parameter int HALF_SIZE   = 20
) (
  input  logic                      clk,
  input  logic                      filter_en,
  input  logic                      vel_en,
  input  logic                      pos_en,
  input  logic signed [ACCEL_W-1:0] sample,
  input  logic signed [VEL_W-1:0]   vel_cur,
  input  logic        [POS_W-1:0]   pos_cur,
  output logic signed [VEL_W-1:0]   vel_nxt,
  output logic        [POS_W-1:0]   pos_nxt,
  output logic                      clamp
);

  localparam int SUM_W = ACCEL_W + 1;
  localparam logic signed [POS_W-1:0] POS_LO = POS_W'(HALF_SIZE);
  localparam logic signed [POS_W-1:0] POS_HI = POS_W'(AXIS_LEN - 1 - HALF_SIZE);

  // Magnitude is taken one bit wider so the most negative sample is not lost.
  function automatic logic signed [ACCEL_W-1:0] dead_zone_shift(
    input logic signed [ACCEL_W-1:0] s
  );
    logic signed [SUM_W-1:0] mag;
    mag = s[ACCEL_W-1] ? -SUM_W'(s) : SUM_W'(s);
    if (mag < SUM_W'(DEADZONE)) return '0;
    return s >>> ACCEL_SHIFT;
  endfunction

  function automatic logic signed [VEL_W-1:0] sat_vel(
    input logic signed [SUM_W-1:0] x
  );
    if (x > SUM_W'(VMAX))  return VEL_W'(VMAX);
    if (x < -SUM_W'(VMAX)) return -VEL_W'(VMAX);
    return x[VEL_W-1:0];
  endfunction

  logic signed [ACCEL_W-1:0] accel_p0;
  logic signed [VEL_W-1:0]   vel_p1;
  logic signed [VEL_W-1:0]   vel_p2;
  logic        [POS_W-1:0]   pos_p2;
  logic                      clamp_p2;
  logic signed [SUM_W-1:0]   vel_sum;
  logic signed [POS_W-1:0]   pos_sum;

  always_comb begin
    vel_sum = SUM_W'(accel_p0) + SUM_W'(vel_cur);
`ifdef FRICTION_EN
    if (accel_p0 == '0) begin
      if (vel_cur[VEL_W-1])
        vel_sum = SUM_W'(vel_cur) + SUM_W'(1);
      else if (vel_cur != '0)
        vel_sum = SUM_W'(vel_cur) - SUM_W'(1);
    end
`endif
    pos_sum = $signed(pos_cur) + POS_W'(vel_p1);
  end

  always_ff @(posedge clk) begin
    // p0: filtered acceleration
    if (filter_en)
      accel_p0 <= dead_zone_shift(sample);
    // p1: saturated velocity
    if (vel_en)
      vel_p1 <= sat_vel(vel_sum);
    // p2: clamped position; hitting a wall kills that axis's velocity
    if (pos_en) begin
      if (pos_sum < POS_LO) begin
        pos_p2   <= POS_LO;
        vel_p2   <= '0;
        clamp_p2 <= 1'b1;
      end else if (pos_sum > POS_HI) begin
        pos_p2   <= POS_HI;
        vel_p2   <= '0;
        clamp_p2 <= 1'b1;
      end else begin
        pos_p2   <= pos_sum;
        vel_p2   <= vel_p1;
        clamp_p2 <= 1'b0;
      end
    end
  end

  assign vel_nxt = vel_p2;
  assign pos_nxt = pos_p2;
  assign clamp   = clamp_p2;

endmodule

// File: rtl/player_motion_integrator.sv
// -----------------------------------------------------------------------------
// player_motion_integrator
// Turns raw accelerometer samples into the player-box centre used by the VGA
// display stage. Once per frame (rising edge of screenEnd, while enabled) it
// runs IDLE -> FILTER -> VEL -> POS -> COMMIT, integrating acceleration into
// velocity and velocity into a clamped position. All outputs change together
// at the end of COMMIT, 4 cycles after the tick edge.
// Ports:
//   clk_25mHz, reset      pixel clock; asynchronous active-high reset
//   screenEnd             high between frames; rising edge = frame tick
//   enable                integration allowed to start
//   recenter              level request: go back to centre, zero velocity
//   accel_valid/ready     sample handshake (ready only in IDLE)
//   accel_raw_x/_y        signed raw samples
//   pos_x/pos_y           centre coordinates, zero-extended to 32 bits
//   vel_x/vel_y           signed velocity
//   wall_hit              one-cycle pulse when any axis clamped
//   busy                  sequencer not in IDLE
// Build option: FRICTION_EN (passed through to axis_integrator).
// -----------------------------------------------------------------------------
module player_motion_integrator
  import square_game_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int HALF_SIZE   = 20,
  parameter int ACCEL_W     = 12,
  parameter int ACCEL_SHIFT = 4,
  parameter int DEADZONE    = 8,
  parameter int VMAX        = 15
) (
  input  logic                      clk_25mHz,
  input  logic                      reset,
  input  logic                      screenEnd,
  input  logic                      enable,
  input  logic                      recenter,
  input  logic                      accel_valid,
  output logic                      accel_ready,
  input  logic signed [ACCEL_W-1:0] accel_raw_x,
  input  logic signed [ACCEL_W-1:0] accel_raw_y,
  output logic        [31:0]        pos_x,
  output logic        [31:0]        pos_y,
  output logic signed [7:0]         vel_x,
  output logic signed [7:0]         vel_y,
  output logic                      wall_hit,
  output logic                      busy
);

  localparam logic [POS_W-1:0] CENTRE_X = centre_of(SCREEN_W);
  localparam logic [POS_W-1:0] CENTRE_Y = centre_of(SCREEN_H);

  motion_state_t state, state_nxt;

  logic                      screen_end_q;
  logic                      tick;
  logic                      recenter_pend;
  logic signed [ACCEL_W-1:0] sample_x, sample_y;
  logic        [POS_W-1:0]   pos_x_q, pos_y_q;
  logic signed [VEL_W-1:0]   vel_x_q, vel_y_q;
  logic                      wall_hit_q;

  logic signed [VEL_W-1:0]   vel_x_nxt, vel_y_nxt;
  logic        [POS_W-1:0]   pos_x_nxt, pos_y_nxt;
  logic                      clamp_x, clamp_y;

  // One registered copy gives a single-cycle tick however long screenEnd stays high.
  assign tick = screenEnd & ~screen_end_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (tick && enable) state_nxt = ST_FILTER;
      ST_FILTER: state_nxt = ST_VEL;
      ST_VEL:    state_nxt = ST_POS;
      ST_POS:    state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_25mHz or posedge reset) begin
    if (reset) begin
      screen_end_q  <= 1'b0;
      state         <= ST_IDLE;
      recenter_pend <= 1'b0;
      sample_x      <= '0;
      sample_y      <= '0;
      pos_x_q       <= CENTRE_X;
      pos_y_q       <= CENTRE_Y;
      vel_x_q       <= '0;
      vel_y_q       <= '0;
      wall_hit_q    <= 1'b0;
    end else begin
      screen_end_q <= screenEnd;
      state        <= state_nxt;
      wall_hit_q   <= 1'b0;

      // Samples are frozen from FILTER onwards, so the integration always
      // sees the value captured before the sequence started.
      if (state == ST_IDLE && accel_valid) begin
        sample_x <= accel_raw_x;
        sample_y <= accel_raw_y;
      end

      // A recenter seen mid-sequence is remembered until the commit.
      if (state == ST_FILTER || state == ST_VEL || state == ST_POS) begin
        if (recenter) recenter_pend <= 1'b1;
      end else begin
        recenter_pend <= 1'b0;
      end

      if (state == ST_COMMIT) begin
        if (recenter || recenter_pend) begin
          pos_x_q <= CENTRE_X;
          pos_y_q <= CENTRE_Y;
          vel_x_q <= '0;
          vel_y_q <= '0;
        end else begin
          pos_x_q    <= pos_x_nxt;
          pos_y_q    <= pos_y_nxt;
          vel_x_q    <= vel_x_nxt;
          vel_y_q    <= vel_y_nxt;
          wall_hit_q <= clamp_x | clamp_y;
        end
      end else if (state == ST_IDLE && recenter) begin
        pos_x_q <= CENTRE_X;
        pos_y_q <= CENTRE_Y;
        vel_x_q <= '0;
        vel_y_q <= '0;
      end
    end
  end

  axis_integrator #(
    .ACCEL_W(ACCEL_W), .ACCEL_SHIFT(ACCEL_SHIFT), .DEADZONE(DEADZONE),
    .VMAX(VMAX), .AXIS_LEN(SCREEN_W), .HALF_SIZE(HALF_SIZE)
  ) u_axis_x (
    .clk       (clk_25mHz),
    .filter_en (state == ST_FILTER),
    .vel_en    (state == ST_VEL),
    .pos_en    (state == ST_POS),
    .sample    (sample_x),
    .vel_cur   (vel_x_q),
    .pos_cur   (pos_x_q),
    .vel_nxt   (vel_x_nxt),
    .pos_nxt   (pos_x_nxt),
    .clamp     (clamp_x)
  );

  axis_integrator #(
    .ACCEL_W(ACCEL_W), .ACCEL_SHIFT(ACCEL_SHIFT), .DEADZONE(DEADZONE),
    .VMAX(VMAX), .AXIS_LEN(SCREEN_H), .HALF_SIZE(HALF_SIZE)
  ) u_axis_y (
    .clk       (clk_25mHz),
    .filter_en (state == ST_FILTER),
    .vel_en    (state == ST_VEL),
    .pos_en    (state == ST_POS),
    .sample    (sample_y),
    .vel_cur   (vel_y_q),
    .pos_cur   (pos_y_q),
    .vel_nxt   (vel_y_nxt),
    .pos_nxt   (pos_y_nxt),
    .clamp     (clamp_y)
  );

  assign pos_x       = {{(32-POS_W){1'b0}}, pos_x_q};
  assign pos_y       = {{(32-POS_W){1'b0}}, pos_y_q};
  assign vel_x       = vel_x_q;
  assign vel_y       = vel_y_q;
  assign wall_hit    = wall_hit_q;
  assign busy        = (state != ST_IDLE);
  assign accel_ready = (state == ST_IDLE);

endmodule

// File: tb/tb_player_motion_integrator.sv
// -----------------------------------------------------------------------------
// tb_player_motion_integrator
// Scoreboard bench: each frame tick pushes the expected commit computed by a
// small behavioural model; the entry is popped and compared when busy falls.
// -----------------------------------------------------------------------------
module tb_player_motion_integrator;

  logic               clk_25mHz = 1'b0;
  logic               reset = 1'b1;
  logic               screenEnd = 1'b0;
  logic               enable = 1'b1;
  logic               recenter = 1'b0;
  logic               accel_valid = 1'b0;
  logic               accel_ready;
  logic signed [11:0] accel_raw_x = '0;
  logic signed [11:0] accel_raw_y = '0;
  logic [31:0]        pos_x, pos_y;
  logic signed [7:0]  vel_x, vel_y;
  logic               wall_hit, busy;

  always #20 clk_25mHz = ~clk_25mHz;

  player_motion_integrator dut (
    .clk_25mHz   (clk_25mHz),
    .reset       (reset),
    .screenEnd   (screenEnd),
    .enable      (enable),
    .recenter    (recenter),
    .accel_valid (accel_valid),
    .accel_ready (accel_ready),
    .accel_raw_x (accel_raw_x),
    .accel_raw_y (accel_raw_y),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .vel_x       (vel_x),
    .vel_y       (vel_y),
    .wall_hit    (wall_hit),
    .busy        (busy)
  );

  typedef struct { int px; int py; int vx; int vy; bit wh; } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_fail = 0;

  // Model state: committed values and the sample the DUT holds.
  int m_px = 320, m_py = 240, m_vx = 0, m_vy = 0, m_sx = 0, m_sy = 0;
  bit m_wh = 0;

  function automatic int filt(input int s);
    int m;
    m = (s < 0) ? -s : s;
    if (m < 8) return 0;
    if (s >= 0) return s / 16;
    return -((-s + 15) / 16);   // floor division for negatives
  endfunction

  function automatic int vstep(input int v, input int a);
    int r;
    r = v + a;
`ifdef FRICTION_EN
    if (a == 0) r = (v > 0) ? v - 1 : ((v < 0) ? v + 1 : 0);
`endif
    if (r > 15) r = 15;
    if (r < -15) r = -15;
    return r;
  endfunction

  task automatic model_frame(input bit rc);
    bit cx, cy;
    cx = 0; cy = 0;
    if (rc) begin
      m_px = 320; m_py = 240; m_vx = 0; m_vy = 0; m_wh = 0;
    end else begin
      m_vx = vstep(m_vx, filt(m_sx));
      m_vy = vstep(m_vy, filt(m_sy));
      m_px = m_px + m_vx;
      m_py = m_py + m_vy;
      if (m_px < 20)  begin m_px = 20;  m_vx = 0; cx = 1; end
      if (m_px > 619) begin m_px = 619; m_vx = 0; cx = 1; end
      if (m_py < 20)  begin m_py = 20;  m_vy = 0; cy = 1; end
      if (m_py > 459) begin m_py = 459; m_vy = 0; cy = 1; end
      m_wh = cx | cy;
    end
    sb.push_back('{m_px, m_py, m_vx, m_vy, m_wh});
  endtask

  task automatic apply_reset();
    @(negedge clk_25mHz);
    reset = 1; accel_valid = 0; accel_raw_x = '0; accel_raw_y = '0;
    screenEnd = 0; recenter = 0; enable = 1;
    @(negedge clk_25mHz);
    reset = 0;
    m_px = 320; m_py = 240; m_vx = 0; m_vy = 0; m_sx = 0; m_sy = 0; m_wh = 0;
  endtask

  task automatic set_sample(input int x, input int y, input bit v);
    @(negedge clk_25mHz);
    accel_raw_x = 12'(x); accel_raw_y = 12'(y); accel_valid = v;
    @(posedge clk_25mHz); #1;
    if (v) begin m_sx = x; m_sy = y; end
  endtask

  // One frame: rc = recenter during VEL, drop_en = enable falls in FILTER,
  // mid_chg = new sample values presented while busy.
  task automatic do_frame(input bit rc, input bit drop_en, input bit mid_chg,
                          input int mx, input int my);
    exp_t e;
    int   n, old_px, old_py;
    old_px = m_px; old_py = m_py;
    @(negedge clk_25mHz);
    screenEnd = 1;
    model_frame(rc);
    @(posedge clk_25mHz); #1;
    n_cmp++; if (busy !== 1'b1 || accel_ready !== 1'b0) begin n_fail++;
      $display("FAIL start: busy=%0b ready=%0b, required busy=1 ready=0", busy, accel_ready); end
    n = 0;
    while (busy === 1'b1 && n < 10) begin
      n_cmp++; if (pos_x !== 32'(old_px) || pos_y !== 32'(old_py) || accel_ready !== 1'b0) begin n_fail++;
        $display("FAIL hold n=%0d: pos=(%0d,%0d) ready=%0b, required (%0d,%0d) ready=0", n, pos_x, pos_y, accel_ready, old_px, old_py); end
      if (drop_en && n == 0) enable = 0;
      if (mid_chg && n == 0) begin accel_raw_x = 12'(mx); accel_raw_y = 12'(my); end
      if (rc && n == 1) recenter = 1;
      if (rc && n == 2) recenter = 0;
      @(posedge clk_25mHz); #1;
      n++;
    end
    n_cmp++; if (n !== 4) begin n_fail++;
      $display("FAIL latency: %0d cycles, required 4", n); end
    n_cmp++; if (accel_ready !== 1'b1) begin n_fail++;
      $display("FAIL ready_back: %0b, required 1", accel_ready); end
    e = sb.pop_front();
    n_cmp++; if (pos_x !== 32'(e.px) || pos_y !== 32'(e.py)) begin n_fail++;
      $display("FAIL pos: (%0d,%0d), required (%0d,%0d)", pos_x, pos_y, e.px, e.py); end
    n_cmp++; if (vel_x !== 8'(e.vx) || vel_y !== 8'(e.vy)) begin n_fail++;
      $display("FAIL vel: (%0d,%0d), required (%0d,%0d)", vel_x, vel_y, e.vx, e.vy); end
    n_cmp++; if (wall_hit !== e.wh) begin n_fail++;
      $display("FAIL wall_hit: %0b, required %0b", wall_hit, e.wh); end
    @(posedge clk_25mHz); #1;
    n_cmp++; if (wall_hit !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL after_commit: wall_hit=%0b busy=%0b, required 0 0", wall_hit, busy); end
    @(negedge clk_25mHz);
    screenEnd = 0; enable = 1; recenter = 0;
    if (mid_chg) begin m_sx = mx; m_sy = my; end
    @(posedge clk_25mHz); #1;
  endtask

  task automatic test_reset();
    @(posedge clk_25mHz); #1;
    n_cmp++; if (pos_x !== 32'd320 || pos_y !== 32'd240 || vel_x !== 8'sd0 || vel_y !== 8'sd0) begin n_fail++;
      $display("FAIL reset_vals: pos=(%0d,%0d) vel=(%0d,%0d), required (320,240) (0,0)", pos_x, pos_y, vel_x, vel_y); end
    n_cmp++; if (wall_hit !== 1'b0 || busy !== 1'b0 || accel_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_ctl: wall_hit=%0b busy=%0b ready=%0b, required 0 0 1", wall_hit, busy, accel_ready); end
    @(negedge clk_25mHz);
    reset = 0;
  endtask

  task automatic test_zero_frames();
    apply_reset();
    do_frame(0, 0, 0, 0, 0);    // reset-cleared sample registers
    set_sample(0, 0, 1);
    do_frame(0, 0, 0, 0, 0);
    do_frame(0, 0, 0, 0, 0);
  endtask

  task automatic test_accel_and_deadzone();
    apply_reset();
    set_sample(160, 0, 1);
    do_frame(0, 0, 0, 0, 0);
    n_cmp++; if (pos_x !== 32'd330 || vel_x !== 8'sd10) begin n_fail++;
      $display("FAIL frame1: pos_x=%0d vel_x=%0d, required 330 10", pos_x, vel_x); end
    do_frame(0, 0, 0, 0, 0);
    n_cmp++; if (pos_x !== 32'd345 || vel_x !== 8'sd15) begin n_fail++;
      $display("FAIL frame2: pos_x=%0d vel_x=%0d, required 345 15", pos_x, vel_x); end
    set_sample(5, 0, 1);
    do_frame(0, 0, 0, 0, 0);
    do_frame(0, 0, 0, 0, 0);
  endtask

  task automatic test_negative();
    apply_reset();
    set_sample(-8, -200, 1);
    for (int i = 0; i < 3; i++) do_frame(0, 0, 0, 0, 0);
    set_sample(-7, 7, 1);
    do_frame(0, 0, 0, 0, 0);
  endtask

  task automatic test_clamp();
    apply_reset();
    set_sample(2000, -2000, 1);
    for (int i = 0; i < 21; i++) do_frame(0, 0, 0, 0, 0);
  endtask

  task automatic test_recenter();
    apply_reset();
    set_sample(2000, 0, 1);
    for (int i = 0; i < 12; i++) do_frame(0, 0, 0, 0, 0);
    n_cmp++; if (pos_x !== 32'd500) begin n_fail++;
      $display("FAIL pre_recenter: pos_x=%0d, required 500", pos_x); end
    do_frame(1, 0, 0, 0, 0);
    do_frame(0, 0, 0, 0, 0);
    @(negedge clk_25mHz);
    recenter = 1;
    @(posedge clk_25mHz); #1;
    n_cmp++; if (pos_x !== 32'd320 || pos_y !== 32'd240 || vel_x !== 8'sd0) begin n_fail++;
      $display("FAIL idle_recenter: pos=(%0d,%0d) vel_x=%0d, required (320,240) 0", pos_x, pos_y, vel_x); end
    recenter = 0;
    m_px = 320; m_py = 240; m_vx = 0; m_vy = 0;
    do_frame(0, 0, 0, 0, 0);
  endtask

  task automatic test_enable();
    bit seen;
    apply_reset();
    set_sample(160, 160, 1);
    @(negedge clk_25mHz);
    enable = 0; screenEnd = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_25mHz); #1;
      if (busy !== 1'b0) seen = 1;
      if (i == 1) screenEnd = 0;
    end
    n_cmp++; if (seen || pos_x !== 32'd320) begin n_fail++;
      $display("FAIL disabled_tick: busy_seen=%0b pos_x=%0d, required 0 320", seen, pos_x); end
    enable = 1;
    do_frame(0, 1, 0, 0, 0);
  endtask

  task automatic test_capture();
    apply_reset();
    set_sample(160, 0, 1);
    do_frame(0, 0, 1, -160, 32);   // held-valid data changes while busy
    do_frame(0, 0, 0, 0, 0);       // uses the sample taken back in IDLE
    set_sample(2000, 2000, 0);     // not valid: ignored
    do_frame(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_sample(2000, 2000, 1);
    do_frame(0, 0, 0, 0, 0);
    @(negedge clk_25mHz);
    screenEnd = 1;
    repeat (3) @(posedge clk_25mHz);   // FILTER, VEL, now POS
    #2;
    n_cmp++; if (busy !== 1'b1) begin n_fail++;
      $display("FAIL mid_busy: busy=%0b, required 1", busy); end
    reset = 1;
    #1;
    n_cmp++; if (pos_x !== 32'd320 || pos_y !== 32'd240 || vel_x !== 8'sd0 || vel_y !== 8'sd0) begin n_fail++;
      $display("FAIL async_reset_pos: pos=(%0d,%0d) vel=(%0d,%0d), required (320,240) (0,0)", pos_x, pos_y, vel_x, vel_y); end
    n_cmp++; if (busy !== 1'b0 || accel_ready !== 1'b1 || wall_hit !== 1'b0) begin n_fail++;
      $display("FAIL async_reset_ctl: busy=%0b ready=%0b wall_hit=%0b, required 0 1 0", busy, accel_ready, wall_hit); end
    @(negedge clk_25mHz);
    reset = 0; screenEnd = 0; accel_valid = 0;
    m_px = 320; m_py = 240; m_vx = 0; m_vy = 0; m_sx = 0; m_sy = 0;
    do_frame(0, 0, 0, 0, 0);           // samples were cleared by reset
  endtask

  initial begin
    test_reset();
    test_zero_frames();
    test_accel_and_deadzone();
    test_negative();
    test_clamp();
    test_recenter();
    test_enable();
    test_capture();
    test_reset_mid();
    n_cmp++; if (sb.size() !== 0) begin n_fail++;
      $display("FAIL scoreboard_left: %0d entries, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
